thiele_coproc_arbiter: RTL and testbench

Shares one external coprocessor port (logic engine / Python executor) among N requesters such as the Thiele CPU's `logic_req` and `py_req` channels. Requester-side req/ack behaviour matches the CPU's existing handshake: req is held until a one-cycle ack. The block arbitrates round-robin, drives a single tagged request to the engine, and routes the response back to the winner. It also enforces a timeout so a dead engine cannot hang the CPU.

---
 rtl/thiele_coproc_pkg.sv | 20 ++
 rtl/thiele_coproc_arbiter_rr_picker.sv | 30 +++
 rtl/thiele_coproc_arbiter.sv | 116 +++++++++++
 tb/tb_thiele_coproc_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/thiele_coproc_pkg.sv
// Shared types and constants for the Thiele coprocessor-port arbiter.
// Sat counters are 8 bits wide; timeout responses carry a recognisable data pattern.
package thiele_coproc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    RESP     = 3'd2,
    RESP_ERR = 3'd3,
    COOL     = 3'd4
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_0000;
  localparam int          SAT_W        = 8;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
    return (&v) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/thiele_coproc_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after last+1 (mod N_REQ).
module rr_picker
  import thiele_coproc_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(last) + k) % N_REQ;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/thiele_coproc_arbiter.sv
// Round-robin arbiter sharing one tagged coprocessor port among N_REQ requesters,
// with per-transaction timeout and counting of stale engine acks.
module thiele_coproc_arbiter
  import thiele_coproc_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_addr,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        err,
  output logic                    eng_req,
  output logic [DATA_W-1:0]       eng_addr,
  output logic [TAG_W-1:0]        eng_tag,
  input  logic                    eng_ack,
  input  logic [TAG_W-1:0]        eng_ack_tag,
  input  logic [DATA_W-1:0]       eng_data,
  output logic                    busy,
  output logic [SAT_W-1:0]        timeout_cnt,
  output logic [SAT_W-1:0]        stale_cnt
);

  localparam int              TCNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_t             state_reg, state_next;
  logic [TAG_W-1:0]   grant_reg, last_reg;
  logic [DATA_W-1:0]  addr_reg, rdata_reg;
  logic [TCNT_W-1:0]  tcnt_reg;
  logic [SAT_W-1:0]   timeout_cnt_reg, stale_cnt_reg;

  logic               pick_valid;
  logic [TAG_W-1:0]   pick_idx;
  logic               ack_ok, timed_out, stale, resp_active;
  logic [N_REQ-1:0]   grant_onehot;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (TAG_W)
  ) u_picker (
    .req   (req),
    .last  (last_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // A matching ack on the final ISSUE cycle beats the timeout.
  assign ack_ok    = (state_reg == ISSUE) && eng_ack && (eng_ack_tag == grant_reg);
  assign timed_out = (state_reg == ISSUE) && !ack_ok && (tcnt_reg == TCNT_LAST);
  assign stale     = eng_ack && !ack_ok;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (pick_valid) state_next = ISSUE;
      ISSUE: begin
        if (ack_ok)         state_next = RESP;
        else if (timed_out) state_next = RESP_ERR;
      end
      RESP:     state_next = COOL;
      RESP_ERR: state_next = COOL;
      COOL:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      last_reg        <= TAG_W'(N_REQ - 1);
      addr_reg        <= '0;
      rdata_reg       <= '0;
      tcnt_reg        <= '0;
      timeout_cnt_reg <= '0;
      stale_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && pick_valid) begin
        grant_reg <= pick_idx;
        last_reg  <= pick_idx;
        addr_reg  <= req_addr[int'(pick_idx)*DATA_W +: DATA_W];
        tcnt_reg  <= '0;
      end else if (state_reg == ISSUE) begin
        tcnt_reg <= tcnt_reg + TCNT_W'(1);
      end
      if (ack_ok) begin
        rdata_reg <= eng_data;
      end else if (timed_out) begin
        rdata_reg       <= DATA_W'(TIMEOUT_DATA) | DATA_W'(grant_reg);
        timeout_cnt_reg <= sat_inc(timeout_cnt_reg);
      end
      if (stale) stale_cnt_reg <= sat_inc(stale_cnt_reg);
    end
  end

  assign resp_active  = (state_reg == RESP) || (state_reg == RESP_ERR);
  assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_reg;

  assign ack         = resp_active ? grant_onehot : '0;
  assign err         = (state_reg == RESP_ERR) ? grant_onehot : '0;
  assign rdata       = resp_active ? rdata_reg : '0;
  assign eng_req     = (state_reg == ISSUE);
  assign eng_addr    = addr_reg;
  assign eng_tag     = grant_reg;
  assign busy        = (state_reg != IDLE);
  assign timeout_cnt = timeout_cnt_reg;
  assign stale_cnt   = stale_cnt_reg;

endmodule

// File: tb/tb_thiele_coproc_arbiter.sv
// Directed bench for thiele_coproc_arbiter: N_REQ=2, TIMEOUT=8, hand-computed expectations.
module tb_thiele_coproc_arbiter;

  localparam int N_REQ   = 2;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int TAG_W   = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_addr;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       rdata;
  logic [N_REQ-1:0]        err;
  logic                    eng_req;
  logic [DATA_W-1:0]       eng_addr;
  logic [TAG_W-1:0]        eng_tag;
  logic                    eng_ack;
  logic [TAG_W-1:0]        eng_ack_tag;
  logic [DATA_W-1:0]       eng_data;
  logic                    busy;
  logic [7:0]              timeout_cnt;
  logic [7:0]              stale_cnt;

  int errors = 0;
  int checks = 0;

  thiele_coproc_arbiter #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .TAG_W   (TAG_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_addr    (req_addr),
    .ack         (ack),
    .rdata       (rdata),
    .err         (err),
    .eng_req     (eng_req),
    .eng_addr    (eng_addr),
    .eng_tag     (eng_tag),
    .eng_ack     (eng_ack),
    .eng_ack_tag (eng_ack_tag),
    .eng_data    (eng_data),
    .busy        (busy),
    .timeout_cnt (timeout_cnt),
    .stale_cnt   (stale_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_ack(input logic [TAG_W-1:0] tag, input logic [31:0] data);
    eng_ack     = 1'b1;
    eng_ack_tag = tag;
    eng_data    = data;
    cyc();
    eng_ack     = 1'b0;
    eng_ack_tag = '0;
    eng_data    = '0;
  endtask

  // One contended transaction: wait (bounded) for ISSUE, ack with the expected tag.
  task automatic do_txn(input string tag, input int exp_idx, input logic [31:0] exp_addr,
                        input logic [31:0] data);
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (eng_req) break;
    end
    check({tag, "_eng_req"}, 32'(eng_req), 32'd1);
    check({tag, "_eng_tag"}, 32'(eng_tag), 32'(exp_idx));
    check({tag, "_eng_addr"}, eng_addr, exp_addr);
    pulse_ack(TAG_W'(exp_idx), data);
    check({tag, "_ack"}, 32'(ack), 32'(1 << exp_idx));
    check({tag, "_rdata"}, rdata, data);
    check({tag, "_err"}, 32'(err), 32'd0);
    $display("txn %s: grant=%0d ack=%b rdata=%h", tag, exp_idx, ack, rdata);
    cyc();
    check({tag, "_cool_no_eng_req"}, 32'(eng_req), 32'd0);
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    req         = '0;
    req_addr    = {32'h0000_0200, 32'h0000_0040};
    eng_ack     = 1'b0;
    eng_ack_tag = '0;
    eng_data    = '0;
    repeat (3) cyc();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_eng_req", 32'(eng_req), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    check("rst_stale_cnt", 32'(stale_cnt), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Single request from 0, engine answers on the third ISSUE cycle
    req = 2'b01;
    cyc();
    check("t1_eng_req", 32'(eng_req), 32'd1);
    check("t1_eng_tag", 32'(eng_tag), 32'd0);
    check("t1_eng_addr", eng_addr, 32'h0000_0040);
    check("t1_busy", 32'(busy), 32'd1);
    cyc();
    cyc();
    check("t1_no_early_ack", 32'(ack), 32'd0);
    pulse_ack(3'd0, 32'hABCD_1234);
    check("t1_ack", 32'(ack), 32'd1);
    check("t1_rdata", rdata, 32'hABCD_1234);
    check("t1_err", 32'(err), 32'd0);
    $display("txn t1: ack=%b rdata=%h err=%b", ack, rdata, err);
    req = 2'b00;
    cyc();
    check("t1_cool_ack", 32'(ack), 32'd0);
    check("t1_cool_busy", 32'(busy), 32'd1);
    cyc();
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Timeout on requester 1: eng_req high for exactly TIMEOUT cycles
    req = 2'b10;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (ack != '0) break;
      if (eng_req) n++;
    end
    check("t3_issue_cycles", 32'(n), 32'(TIMEOUT));
    check("t3_ack", 32'(ack), 32'd2);
    check("t3_err", 32'(err), 32'd2);
    check("t3_rdata", rdata, 32'hDEAD_0001);
    check("t3_timeout_cnt", 32'(timeout_cnt), 32'd1);
    check("t3_eng_req_low", 32'(eng_req), 32'd0);
    $display("txn t3: ack=%b err=%b rdata=%h timeout_cnt=%0d", ack, err, rdata, timeout_cnt);
    req = 2'b00;
    cyc();
    cyc();

    // Late ack while idle is dropped and counted
    check("t4_idle", 32'(busy), 32'd0);
    pulse_ack(3'd1, 32'h5555_5555);
    check("t4_no_ack", 32'(ack), 32'd0);
    check("t4_stale_cnt", 32'(stale_cnt), 32'd1);
    check("t4_still_idle", 32'(busy), 32'd0);
    $display("txn t4: late ack stale_cnt=%0d", stale_cnt);

    // Wrong-tag ack during ISSUE, then the correct one
    req_addr = {32'h0000_0200, 32'h0000_0080};
    req = 2'b01;
    cyc();
    check("t5_eng_tag", 32'(eng_tag), 32'd0);
    check("t5_eng_addr", eng_addr, 32'h0000_0080);
    pulse_ack(3'd1, 32'h0000_0BAD);
    check("t5_wrong_no_ack", 32'(ack), 32'd0);
    check("t5_wrong_eng_req", 32'(eng_req), 32'd1);
    check("t5_wrong_stale", 32'(stale_cnt), 32'd2);
    pulse_ack(3'd0, 32'h1234_5678);
    check("t5_ack", 32'(ack), 32'd1);
    check("t5_rdata", rdata, 32'h1234_5678);
    check("t5_err", 32'(err), 32'd0);
    check("t5_stale_kept", 32'(stale_cnt), 32'd2);
    $display("txn t5: ack=%b rdata=%h stale_cnt=%0d", ack, rdata, stale_cnt);
    req = 2'b00;
    cyc();
    cyc();

    // Matching ack on the last ISSUE cycle (tcnt = TIMEOUT-1) beats the timeout
    req = 2'b10;
    cyc();
    check("t6_eng_tag", 32'(eng_tag), 32'd1);
    check("t6_eng_addr", eng_addr, 32'h0000_0200);
    repeat (TIMEOUT - 1) cyc();
    check("t6_still_issue", 32'(eng_req), 32'd1);
    check("t6_no_ack_yet", 32'(ack), 32'd0);
    pulse_ack(3'd1, 32'hCAFE_F00D);
    check("t6_ack", 32'(ack), 32'd2);
    check("t6_err", 32'(err), 32'd0);
    check("t6_rdata", rdata, 32'hCAFE_F00D);
    check("t6_timeout_cnt", 32'(timeout_cnt), 32'd1);
    $display("txn t6: ack=%b err=%b rdata=%h", ack, err, rdata);
    req = 2'b00;
    cyc();
    cyc();

    // Reset in the middle of ISSUE
    req = 2'b01;
    cyc();
    check("t7_in_issue", 32'(eng_req), 32'd1);
    cyc();
    rst_n = 1'b0;
    cyc();
    check("t7_eng_req", 32'(eng_req), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_ack", 32'(ack), 32'd0);
    check("t7_timeout_cnt", 32'(timeout_cnt), 32'd0);
    check("t7_stale_cnt", 32'(stale_cnt), 32'd0);
    $display("txn t7: reset mid-issue busy=%b", busy);
    rst_n = 1'b1;

    // Both held continuously: grants 0,1,0,1
    req_addr = {32'h0000_0300, 32'h0000_0100};
    req = 2'b11;
    do_txn("c0", 0, 32'h0000_0100, 32'h0000_A000);
    do_txn("c1", 1, 32'h0000_0300, 32'h0000_B001);
    do_txn("c2", 0, 32'h0000_0100, 32'h0000_A002);
    do_txn("c3", 1, 32'h0000_0300, 32'h0000_B003);
    req = 2'b00;
    cyc();
    cyc();
    check("end_idle", 32'(busy), 32'd0);
    check("end_timeout_cnt", 32'(timeout_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
